// File: rtl/dram_cache_pkg.sv
// Types and constants shared along the DRAM-cache tag path. The issuer and tag_compare
// both import this package.
package dram_cache_pkg;

    localparam int AXI_ADDR_W    = 32;
    localparam int AXI_ID_W      = 4;
    localparam int IDX_BITS      = 10;
    localparam int OFF_BITS      = 6;
    localparam int TAD_BURST_LEN = 4;

    typedef struct packed {
        logic                  is_write;
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
    } tag_entry_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } issue_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the read request and bit 1 is the write request.
// When both are requesting, the channel that was not granted last time wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_write;

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last_write ? 2'b01 : 2'b10;
    end

    // Starting at 1 means a read wins the first contested cycle after reset.
    always_ff @(posedge clk) begin
        if (rst)
            last_write <= 1'b1;
        else if (accept)
            last_write <= grant[1];
    end

endmodule

// File: rtl/tag_req_issuer.sv
// Tag-path front end. It takes one host AR or AW request at a time, pushes it into the
// tag FIFO, and issues the matching TAD burst read to the memory controller.
module tag_req_issuer
    import dram_cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = AXI_ADDR_W,
    parameter int ID_WIDTH        = AXI_ID_W,
    parameter int INDEX_WIDTH     = IDX_BITS,
    parameter int OFFSET_WIDTH    = OFF_BITS,
    parameter int BURST_LEN       = TAD_BURST_LEN,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_WIDTH-1:0]          arid_i,
    input  logic [ADDR_WIDTH-1:0]        araddr_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    input  logic [ID_WIDTH-1:0]          awid_i,
    input  logic [ADDR_WIDTH-1:0]        awaddr_i,
    input  logic                         awvalid_i,
    output logic                         awready_o,
    output logic [ID_WIDTH-1:0]          mc_arid_o,
    output logic [ADDR_WIDTH-1:0]        mc_araddr_o,
    output logic [7:0]                   mc_arlen_o,
    output logic                         mc_arvalid_o,
    input  logic                         mc_arready_i,
    input  logic                         mc_rvalid_i,
    input  logic                         mc_rready_i,
    input  logic                         mc_rlast_i,
    input  logic                         tag_fifo_afull_i,
    output logic                         tag_fifo_wren_o,
    output logic [ADDR_WIDTH+ID_WIDTH:0] tag_fifo_wdata_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // A TAD read covers the whole set, so only the index field of the address is kept.
    function automatic logic [ADDR_WIDTH-1:0] tad_addr(input logic [ADDR_WIDTH-1:0] a);
        tad_addr = '0;
        for (int i = OFFSET_WIDTH; i < INDEX_WIDTH + OFFSET_WIDTH; i++)
            tad_addr[i] = a[i];
    endfunction

    issue_state_t          state, state_nxt;
    logic [CNT_W-1:0]      out_cnt;
    logic [1:0]            grant;
    logic                  can_accept, host_hs, ar_hs, r_done, sel_w;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({awvalid_i, arvalid_i}),
        .accept (host_hs),
        .grant  (grant)
    );

    assign can_accept = !rst && (state == S_IDLE) && !tag_fifo_afull_i &&
                        (out_cnt < CNT_W'(MAX_OUTSTANDING));
    assign arready_o  = can_accept & grant[0];
    assign awready_o  = can_accept & grant[1];
    assign host_hs    = (arready_o & arvalid_i) | (awready_o & awvalid_i);
    assign ar_hs      = mc_arvalid_o & mc_arready_i;
    assign r_done     = mc_rvalid_i & mc_rready_i & mc_rlast_i;
    assign mc_arlen_o = 8'(BURST_LEN - 1);

    assign sel_w    = grant[1];
    assign sel_id   = sel_w ? awid_i : arid_i;
    assign sel_addr = sel_w ? awaddr_i : araddr_i;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_IDLE && host_hs)
            state_nxt = S_ISSUE;
        else if (state == S_ISSUE && ar_hs)
            state_nxt = S_IDLE;
    end

    // The FIFO push and the first cycle of mc_arvalid start together, so the tag entry
    // can never arrive after its R data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_fifo_wren_o  <= 1'b0;
            tag_fifo_wdata_o <= '0;
            mc_arvalid_o     <= 1'b0;
            mc_arid_o        <= '0;
            mc_araddr_o      <= '0;
        end else begin
            tag_fifo_wren_o <= 1'b0;
            if (host_hs) begin
                tag_fifo_wren_o  <= 1'b1;
                tag_fifo_wdata_o <= {sel_w, sel_id, sel_addr};
                mc_arvalid_o     <= 1'b1;
                mc_arid_o        <= sel_id;
                mc_araddr_o      <= tad_addr(sel_addr);
            end else if (ar_hs) begin
                mc_arvalid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_cnt <= '0;
        else if (ar_hs && !r_done)
            out_cnt <= out_cnt + CNT_W'(1);
        else if (r_done && !ar_hs && out_cnt != '0)
            out_cnt <= out_cnt - CNT_W'(1);
    end

    // An rlast with nothing outstanding means the memory controller broke protocol.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) r_done |-> (out_cnt != '0));

endmodule
